conv_kxk_stream: RTL and testbench

CONV_KXK_STREAM -- requirements
Module: conv_kxk_stream

---
 rtl/conv_kxk_stream.sv | 155 +++++++++++++++
 tb/tb_conv_kxk_stream.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_kxk_stream.sv
// Streaming KxK convolution MAC: accepts one window at a time, folds
// LANES taps per clock into the accumulator, then shifts, relus and saturates.
module conv_kxk_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 32,
   parameter int K          = 3,
   parameter int LANES      = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [K*K*DATA_WIDTH-1:0]     win_flat,
   input  logic [K*K*DATA_WIDTH-1:0]     wgt_flat,
   input  logic [ACC_WIDTH-1:0]          bias,
   input  logic [4:0]                    shift,
   input  logic                          relu_en,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUT_WIDTH-1:0]          result
);

   localparam int N     = K * K;
   localparam int NB    = (N + LANES - 1) / LANES;
   localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
   localparam int NBITS = N * DATA_WIDTH;
   localparam logic [BW-1:0] LAST = BW'(NB - 1);
   localparam logic signed [ACC_WIDTH-1:0] OMAX =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] OMIN = ~OMAX;

   if (OUT_WIDTH > ACC_WIDTH || K < 1 || LANES < 1 || LANES > K * K)
   begin : g_param_err
      $error("conv_kxk_stream: illegal parameter combination");
   end

   typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

   state_t                        state_q, state_d;
   logic [BW-1:0]                 beat_q, beat_d;
   logic [NBITS-1:0]              win_q, win_d;
   logic [NBITS-1:0]              wgt_q, wgt_d;
   logic [4:0]                    shift_q, shift_d;
   logic                          relu_q, relu_d;
   logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [OUT_WIDTH-1:0]          res_q, res_d;
   logic                          vld_q, vld_d;

   logic                          accept;
   logic signed [ACC_WIDTH-1:0]   beat_sum, a_ext, w_ext;
   logic signed [ACC_WIDTH-1:0]   sum_fin, shifted, relued, clamped;
   int                            tap;

   assign in_ready  = (state_q == IDLE) | ((state_q == OUT) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = vld_q;
   assign result    = res_q;

   // Taps past N in the last beat are simply skipped.
   always_comb begin
      beat_sum = '0;
      a_ext    = '0;
      w_ext    = '0;
      tap      = 0;
      for (int l = 0; l < LANES; l++) begin
         tap = int'(beat_q) * LANES + l;
         if (tap < N) begin
            a_ext = ACC_WIDTH'($signed(win_q[tap*DATA_WIDTH +: DATA_WIDTH]));
            w_ext = ACC_WIDTH'($signed(wgt_q[tap*DATA_WIDTH +: DATA_WIDTH]));
            beat_sum = beat_sum + a_ext * w_ext;
         end
      end
   end

   always_comb begin
      sum_fin = acc_q + beat_sum;
      shifted = sum_fin >>> shift_q;
      relued  = (relu_q && shifted[ACC_WIDTH-1]) ? '0 : shifted;
      if (relued > OMAX) begin
         clamped = OMAX;
      end else if (relued < OMIN) begin
         clamped = OMIN;
      end else begin
         clamped = relued;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      win_d   = win_q;
      wgt_d   = wgt_q;
      shift_d = shift_q;
      relu_d  = relu_q;
      acc_d   = acc_q;
      res_d   = res_q;
      vld_d   = vld_q;
      unique case (state_q)
         IDLE: ;
         RUN: begin
            acc_d = sum_fin;
            if (beat_q == LAST) begin
               res_d   = clamped[OUT_WIDTH-1:0];
               vld_d   = 1'b1;
               state_d = OUT;
            end else begin
               beat_d = beat_q + BW'(1);
            end
         end
         OUT: begin
            if (out_ready) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A new window overrides the OUT -> IDLE return.
      if (accept) begin
         win_d   = win_flat;
         wgt_d   = wgt_flat;
         shift_d = shift;
         relu_d  = relu_en;
         acc_d   = bias;
         beat_d  = '0;
         state_d = RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
         win_q   <= '0;
         wgt_q   <= '0;
         shift_q <= '0;
         relu_q  <= 1'b0;
         acc_q   <= '0;
         res_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         win_q   <= win_d;
         wgt_q   <= wgt_d;
         shift_q <= shift_d;
         relu_q  <= relu_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         vld_q   <= vld_d;
      end
   end

endmodule

// File: tb/tb_conv_kxk_stream.sv
// Bench for conv_kxk_stream: three configurations driven from shared data,
// checked against an arithmetic reference and hand-computed constants.
module tb_conv_kxk_stream;

   localparam int DW = 8;
   localparam int AW = 32;
   localparam int N  = 9;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [N*DW-1:0]      win_flat, wgt_flat;
   logic signed [AW-1:0] bias;
   logic [4:0]           shift;
   logic                 relu_en;
   logic                 in_valid[3];
   logic                 out_ready[3];
   logic                 in_ready[3];
   logic                 out_valid[3];
   logic signed [31:0]   res[3];
   logic signed [31:0]   res_a, res_c;
   logic signed [15:0]   res_b;

   int nb[3] = '{9, 9, 3};
   int ow[3] = '{32, 16, 32};

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   assign res[0] = res_a;
   assign res[1] = 32'(res_b);
   assign res[2] = res_c;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conv_kxk_stream #(.DATA_WIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(32),
                     .K(3), .LANES(1)) u_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .win_flat(win_flat), .wgt_flat(wgt_flat), .bias(bias),
      .shift(shift), .relu_en(relu_en),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(res_a));

   conv_kxk_stream #(.DATA_WIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(16),
                     .K(3), .LANES(1)) u_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .win_flat(win_flat), .wgt_flat(wgt_flat), .bias(bias),
      .shift(shift), .relu_en(relu_en),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(res_b));

   conv_kxk_stream #(.DATA_WIDTH(8), .ACC_WIDTH(32), .OUT_WIDTH(32),
                     .K(3), .LANES(4)) u_c (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .win_flat(win_flat), .wgt_flat(wgt_flat), .bias(bias),
      .shift(shift), .relu_en(relu_en),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .result(res_c));

   task automatic chk(input bit ok, input string nm,
                      input longint act, input longint exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d want %0d", nm, act, exp);
   endtask

   // Dot product plus bias, wrapped to 32 bits, then floor shift, relu, clamp.
   function automatic longint model(input logic [N*DW-1:0] a,
                                    input logic [N*DW-1:0] w,
                                    input logic signed [31:0] b,
                                    input logic [4:0] sh,
                                    input logic re, input int outw);
      longint s, mx, mn;
      int     s32;
      s = longint'(b);
      for (int i = 0; i < N; i++)
         s += longint'($signed(a[i*DW +: DW])) * longint'($signed(w[i*DW +: DW]));
      s32 = int'(s);
      s32 = s32 >>> sh;
      if (re && s32 < 0) s32 = 0;
      mx = (longint'(1) << (outw - 1)) - 1;
      mn = -mx - 1;
      if (longint'(s32) > mx) return mx;
      if (longint'(s32) < mn) return mn;
      return longint'(s32);
   endfunction

   longint             exp_q[3][$];
   int                 due_q[3][$];
   bit                 busy[3];
   logic               pv[3], pr[3];
   logic signed [31:0] pres[3];
   longint             e;
   int                 t;

   always @(negedge clk) begin
      if (rst) begin
         for (int d = 0; d < 3; d++) begin
            exp_q[d].delete();
            due_q[d].delete();
            busy[d] = 0;
            pv[d]   = 0;
            pr[d]   = 0;
            pres[d] = '0;
         end
      end else begin
         for (int d = 0; d < 3; d++) begin
            if (out_valid[d]) begin
               if (!pv[d] || pr[d]) begin
                  if (exp_q[d].size() == 0) begin
                     chk(0, "unexpected result", res[d], 0);
                  end else begin
                     e = exp_q[d].pop_front();
                     t = due_q[d].pop_front();
                     chk(res[d] == e, "model result", res[d], e);
                     chk(cyc == t, "model latency", cyc, t);
                  end
                  busy[d] = 0;
               end else begin
                  chk(res[d] == pres[d], "hold result", res[d], pres[d]);
               end
               chk(in_ready[d] == out_ready[d], "in_ready in OUT",
                   in_ready[d], out_ready[d]);
            end else begin
               chk(in_ready[d] == !busy[d], "in_ready idle/run",
                   in_ready[d], !busy[d]);
            end
            if (in_valid[d] && in_ready[d]) begin
               exp_q[d].push_back(model(win_flat, wgt_flat, bias, shift,
                                        relu_en, ow[d]));
               due_q[d].push_back(cyc + 1 + nb[d]);
               busy[d] = 1;
            end
            pv[d]   = out_valid[d];
            pr[d]   = out_ready[d];
            pres[d] = res[d];
         end
      end
   end

   task automatic set_uni(input int a, input int w, input int b,
                          input int sh, input bit re);
      for (int i = 0; i < N; i++) begin
         win_flat[i*DW +: DW] = 8'(a);
         wgt_flat[i*DW +: DW] = 8'(w);
      end
      bias    = b;
      shift   = 5'(sh);
      relu_en = re;
   endtask

   task automatic send(input int d);
      int n;
      n = 0;
      in_valid[d] = 1'b1;
      @(negedge clk);
      while (!in_ready[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(n < 20, "accept timeout", n, 0);
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
   endtask

   task automatic wait_res(input int d, input longint exp, input string nm);
      int lat;
      lat = 0;
      while (!out_valid[d] && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk(out_valid[d] == 1'b1, {nm, " valid"}, out_valid[d], 1);
      chk(lat == nb[d], {nm, " latency"}, lat, nb[d]);
      chk(res[d] == exp, nm, res[d], exp);
   endtask

   task automatic release_out(input int d);
      out_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[d] = 1'b0;
      chk(out_valid[d] == 1'b0, "valid drop", out_valid[d], 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b0;
      end
      set_uni(0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk(out_valid[d] == 1'b0, "reset out_valid", out_valid[d], 0);
         chk(res[d] == 0, "reset result", res[d], 0);
      end
      rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++)
         chk(in_ready[d] == 1'b1, "in_ready after reset", in_ready[d], 1);

      set_uni(1, 1, 0, 0, 0);
      send(0); wait_res(0, 9, "all ones"); release_out(0);
      set_uni(-128, -128, 0, 0, 0);
      send(1); wait_res(1, 32767, "sat pos"); release_out(1);
      set_uni(-128, 127, 0, 0, 0);
      send(1); wait_res(1, -32768, "sat neg"); release_out(1);
      set_uni(1, -1, 4, 0, 0);
      send(0); wait_res(0, -5, "neg bias"); release_out(0);
      set_uni(1, -1, 4, 0, 1);
      send(0); wait_res(0, 0, "relu"); release_out(0);
      set_uni(2, 2, 0, 2, 0);
      send(0); wait_res(0, 9, "shift"); release_out(0);

      set_uni(0, 1, 10, 0, 0);
      for (int i = 0; i < N; i++) win_flat[i*DW +: DW] = 8'(i);
      send(2); wait_res(2, 46, "lanes4 ramp"); release_out(2);
      set_uni(-3, 7, -100, 1, 0);
      send(2); wait_res(2, -145, "lanes4 floor"); release_out(2);

      set_uni(1, 1, 0, 0, 0);
      send(0); wait_res(0, 9, "bp first");
      repeat (5) begin
         @(posedge clk);
         #1;
         chk(out_valid[0] == 1'b1, "bp valid", out_valid[0], 1);
         chk(res[0] == 9, "bp hold", res[0], 9);
         chk(in_ready[0] == 1'b0, "bp in_ready", in_ready[0], 0);
      end
      set_uni(2, 2, 0, 0, 0);
      in_valid[0]  = 1'b1;
      out_ready[0] = 1'b1;
      #1;
      chk(in_ready[0] == 1'b1, "bp accept ready", in_ready[0], 1);
      @(posedge clk);
      #1;
      in_valid[0]  = 1'b0;
      out_ready[0] = 1'b0;
      chk(out_valid[0] == 1'b0, "bp valid fall", out_valid[0], 0);
      wait_res(0, 36, "bp second"); release_out(0);

      set_uni(5, 3, 0, 0, 0);
      send(0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk(out_valid[0] == 1'b0, "rst async valid", out_valid[0], 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk(out_valid[0] == 1'b0, "rst abort valid", out_valid[0], 0);
      chk(res[0] == 0, "rst abort result", res[0], 0);
      chk(in_ready[0] == 1'b1, "rst abort ready", in_ready[0], 1);
      set_uni(3, -2, 7, 0, 0);
      send(0); wait_res(0, -47, "after abort"); release_out(0);

      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++)
         chk(exp_q[d].size() == 0, "pending results", exp_q[d].size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
